countdown_timer_bank: RTL and testbench
=======================================

// Module: countdown_timer_bank
// PURPOSE
//  Bank of CHANNELS independent, programmable down-counters sharing one prescaled tick.
//  Replaces single-shot countdowns in the game logic: jump airtime, spawn delays, power-up
//  timeouts, start-screen countdown.
//  Each channel supports load, start, pause and clear, plus one-shot or periodic
//  (auto-reload) mode. Each channel reports a one-cycle expiry pulse and a sticky done flag.
// PARAMETERS
//  WIDTH     8  bits per channel counter and seed
//  CHANNELS  4  number of independent channels (>=1)
//  PRESCALE  1  clocks per count tick (>=1); 1 = tick every clock
// PORTS
//  Clk         in   1               system clock
//  Reset       in   1               asynchronous, active-high reset
//  load        in   CHANNELS        per-channel: count<=seed, reload<=seed
//  seed        in   CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//  start       in   CHANNELS        per-channel run / resume request
//  stop        in   CHANNELS        per-channel pause request
//  periodic    in   CHANNELS        per-channel mode: 1 = auto-reload, 0 = one-shot
//  clear_done  in   CHANNELS        per-channel clear of sticky done
//  count       out  CHANNELS*WIDTH  current count per channel
//  busy        out  CHANNELS        channel is in RUN
//  done_pulse  out  CHANNELS        1-cycle expiry strobe
//  done        out  CHANNELS        sticky expiry flag
//  any_done    out  1               OR of done
// BEHAVIOUR
//  Reset (async, active-high)
//   - Every channel: state IDLE, count=0, reload=0, done=0, done_pulse=0.
//   - Prescaler counter = 0.
//  Prescaler
//   - Free-running 0..PRESCALE-1.
//   - tick=1 when the counter equals PRESCALE-1. PRESCALE=1 gives tick=1 every cycle.
//   - Shared by all channels; not affected by load, start or stop.
//  Per-channel states: IDLE, RUN, EXPIRED. All outputs are registered.
//  Control priority per channel, same cycle: load > stop > start.
//  load (any state)
//   - count<=seed, reload<=seed, done<=0, state<=IDLE.
//   - Suppresses any expiry in that cycle.
//  IDLE
//   - start -> RUN. count is kept, so stop/start acts as pause/resume.
//  RUN, no tick: hold.
//  RUN, tick, count!=0: count<=count-1.
//  RUN, tick, count==0 (expiry)
//   - done_pulse<=1 for exactly one cycle; done<=1.
//   - periodic=1: count<=reload, remain in RUN.
//   - periodic=0: count stays 0, state<=EXPIRED.
//  RUN, stop: state<=IDLE, count held. A tick in the same cycle is ignored.
//  EXPIRED, start: count<=reload, state<=RUN.
//  EXPIRED, stop: state<=IDLE.
//  Period and latency
//   - Expiry fires on the (seed+1)th tick after start: counts seed..0, then expires on the next tick.
//   - seed=0 in periodic mode expires on every tick.
//   - count and done_pulse update on the clock edge after the tick cycle.
//  Wrap-around
//   - count never decrements below 0.
//   - No underflow to 2^WIDTH-1 in any mode.
//  clear_done
//   - done<=0.
//   - If an expiry occurs in the same cycle, set wins and done stays 1.
//  periodic is sampled at the expiry tick; it may change while running.
//  busy = (state==RUN).
//  any_done = |done (combinational OR of registers).
//  Reset mid-count: everything returns to reset values immediately; no done_pulse is emitted.
// TESTING
//  1 One-shot, PRESCALE=1, ch0: load seed=3, then start
//    -> count 3,2,1,0.
//    -> done_pulse on the 4th tick edge; done=1; busy=0; count holds 0.
//  2 Periodic, ch1: seed=2
//    -> done_pulse every 3 cycles, repeating.
//    -> count sequence 2,1,0,2,1,0.
//    -> busy stays 1.
//  3 Pause/resume, seed=10
//    -> stop at count=6: count holds 6 for 20 cycles.
//    -> start resumes 5,4,...
//    -> total ticks to expiry = 11.
//  4 Priority checks
//    -> load with an expiring tick: no done_pulse; count=seed.
//    -> clear_done with an expiry: done=1.
//    -> load+stop+start together: load effect only.
//  5 PRESCALE=4, seed=1
//    -> count decrements once per 4 clocks.
//    -> expiry 8 clocks after the first tick boundary.
//    -> all 4 channels with different seeds expire independently; any_done tracks the OR.
//  6 Async Reset asserted mid-count, between clock edges
//    -> count, done, busy and done_pulse go to 0 immediately.
//    -> after release, the channel stays IDLE until load/start.

Source files
------------

// File: rtl/countdown_timer_bank.sv
// countdown_timer_bank
//   A bank of CHANNELS independent programmable down-counters that share one
//   prescaled tick. Each channel can be loaded, started, paused and cleared,
//   and runs either one-shot or periodic (auto-reload). On expiry a channel
//   raises a one-cycle done_pulse and sets a sticky done flag.
// Ports
//   Clk, Reset   clock, asynchronous active-high reset
//   load         per channel: count<=seed, reload<=seed, done<=0, go IDLE
//   seed         channel i at [i*WIDTH +: WIDTH]
//   start        per channel run / resume request
//   stop         per channel pause request
//   periodic     per channel mode, 1 = auto-reload (sampled at expiry)
//   clear_done   per channel clear of sticky done (an expiry in the same cycle wins)
//   count        current count, channel i at [i*WIDTH +: WIDTH]
//   busy         channel is running
//   done_pulse   one-cycle expiry strobe
//   done         sticky expiry flag
//   any_done     OR of done
module countdown_timer_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [CHANNELS-1:0]          load,
  input  logic [CHANNELS*WIDTH-1:0]    seed,
  input  logic [CHANNELS-1:0]          start,
  input  logic [CHANNELS-1:0]          stop,
  input  logic [CHANNELS-1:0]          periodic,
  input  logic [CHANNELS-1:0]          clear_done,
  output logic [CHANNELS*WIDTH-1:0]    count,
  output logic [CHANNELS-1:0]          busy,
  output logic [CHANNELS-1:0]          done_pulse,
  output logic [CHANNELS-1:0]          done,
  output logic                         any_done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  logic [PW-1:0]       pre_q, pre_d;
  logic                tick_c;

  state_e              state_q  [CHANNELS];
  state_e              state_d  [CHANNELS];
  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    count_d  [CHANNELS];
  logic [WIDTH-1:0]    reload_q [CHANNELS];
  logic [WIDTH-1:0]    reload_d [CHANNELS];
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic [CHANNELS-1:0] busy_q, busy_d;

  // Shared free-running prescaler; tick on the last phase of each period.
  always_comb begin
    tick_c = (pre_q == PW'(PRESCALE - 1));
    pre_d  = tick_c ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Per-channel next state: load > stop > start, then tick-driven counting.
  always_comb begin
    done_d  = done_q;
    pulse_d = '0;
    busy_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      reload_d[i] = reload_q[i];

      if (load[i]) begin
        count_d[i]  = seed[i*WIDTH +: WIDTH];
        reload_d[i] = seed[i*WIDTH +: WIDTH];
        done_d[i]   = 1'b0;
        state_d[i]  = ST_IDLE;
      end else if (stop[i]) begin
        // Pause: count is held, a coincident tick is dropped.
        state_d[i] = ST_IDLE;
      end else begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (start[i]) state_d[i] = ST_RUN;
          end
          ST_RUN: begin
            if (tick_c) begin
              if (count_q[i] != '0) begin
                count_d[i] = count_q[i] - WIDTH'(1);
              end else begin
                // Expiry: count never wraps below zero.
                pulse_d[i] = 1'b1;
                done_d[i]  = 1'b1;
                if (periodic[i]) count_d[i] = reload_q[i];
                else             state_d[i] = ST_EXPIRED;
              end
            end
          end
          ST_EXPIRED: begin
            if (start[i]) begin
              count_d[i] = reload_q[i];
              state_d[i] = ST_RUN;
            end
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end

      // A same-cycle expiry beats clear_done.
      if (clear_done[i] && !pulse_d[i]) done_d[i] = 1'b0;

      busy_d[i] = (state_d[i] == ST_RUN);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= ST_IDLE;
        count_q[i]  <= '0;
        reload_q[i] <= '0;
      end
      done_q  <= '0;
      pulse_q <= '0;
      busy_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
      end
      done_q  <= done_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_count
    assign count[g*WIDTH +: WIDTH] = count_q[g];
  end

  assign busy       = busy_q;
  assign done_pulse = pulse_q;
  assign done       = done_q;
  assign any_done   = |done_q;

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Testbench for countdown_timer_bank: two instances (PRESCALE 1 and 4) share
// the same stimulus and are compared every cycle against a behavioural model,
// plus directed vectors and sequences on specific channels.
module tb_countdown_timer_bank;

  localparam int CH = 4;
  localparam int W  = 8;

  logic            Clk, Reset;
  logic [CH-1:0]   load, start, stop, periodic, clear_done;
  logic [CH*W-1:0] seed;

  logic [CH*W-1:0] count1, count4;
  logic [CH-1:0]   busy1, busy4, pulse1, pulse4, done1, done4;
  logic            any1, any4;

  countdown_timer_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .load(load), .seed(seed), .start(start), .stop(stop),
    .periodic(periodic), .clear_done(clear_done), .count(count1), .busy(busy1),
    .done_pulse(pulse1), .done(done1), .any_done(any1));

  countdown_timer_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .load(load), .seed(seed), .start(start), .stop(stop),
    .periodic(periodic), .clear_done(clear_done), .count(count4), .busy(busy4),
    .done_pulse(pulse4), .done(done4), .any_done(any4));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model, index 0 = PRESCALE 1, index 1 = PRESCALE 4.
  // Mode: 0 idle, 1 running, 2 expired (finished one-shot).
  int m_cnt   [2][CH];
  int m_rel   [2][CH];
  int m_mode  [2][CH];
  int m_done  [2][CH];
  int m_pulse [2][CH];
  int m_edges [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_edges[d] = 0;
      for (int c = 0; c < CH; c++) begin
        m_cnt[d][c] = 0; m_rel[d][c] = 0; m_mode[d][c] = 0;
        m_done[d][c] = 0; m_pulse[d][c] = 0;
      end
    end
  endtask

  // One clock edge of the model using the inputs held across that edge.
  task automatic model_step();
    int p;
    bit tick;
    for (int d = 0; d < 2; d++) begin
      p    = (d == 0) ? 1 : 4;
      tick = ((m_edges[d] % p) == p - 1);
      m_edges[d]++;
      for (int c = 0; c < CH; c++) begin
        m_pulse[d][c] = 0;
        if (load[c]) begin
          m_cnt[d][c]  = int'(seed[c*W +: W]);
          m_rel[d][c]  = m_cnt[d][c];
          m_done[d][c] = 0;
          m_mode[d][c] = 0;
        end else if (stop[c]) begin
          m_mode[d][c] = 0;
        end else if (start[c] && m_mode[d][c] == 0) begin
          m_mode[d][c] = 1;
        end else if (start[c] && m_mode[d][c] == 2) begin
          m_cnt[d][c]  = m_rel[d][c];
          m_mode[d][c] = 1;
        end else if (m_mode[d][c] == 1 && tick) begin
          if (m_cnt[d][c] > 0) begin
            m_cnt[d][c] = m_cnt[d][c] - 1;
          end else begin
            m_pulse[d][c] = 1;
            m_done[d][c]  = 1;
            if (periodic[c]) m_cnt[d][c] = m_rel[d][c];
            else             m_mode[d][c] = 2;
          end
        end
        if (clear_done[c] && m_pulse[d][c] == 0) m_done[d][c] = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [CH*W-1:0] ec;
    logic [CH-1:0]   eb, ep, ed;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        ec[c*W +: W] = W'(m_cnt[d][c]);
        eb[c] = (m_mode[d][c] == 1);
        ep[c] = (m_pulse[d][c] != 0);
        ed[c] = (m_done[d][c] != 0);
      end
      if (d == 0) begin
        check("p1_count", count1, ec);
        check("p1_busy",  32'(busy1),  32'(eb));
        check("p1_pulse", 32'(pulse1), 32'(ep));
        check("p1_done",  32'(done1),  32'(ed));
        check("p1_any",   32'(any1),   32'(|ed));
      end else begin
        check("p4_count", count4, ec);
        check("p4_busy",  32'(busy4),  32'(eb));
        check("p4_pulse", 32'(pulse4), 32'(ep));
        check("p4_done",  32'(done4),  32'(ed));
        check("p4_any",   32'(any4),   32'(|ed));
      end
    end
  endtask

  task automatic idle_inputs();
    load = '0; start = '0; stop = '0; periodic = '0; clear_done = '0; seed = '0;
  endtask

  // Inputs are driven just after an edge; the next edge samples them.
  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    compare_all();
    @(negedge Clk);
    Reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic       ld, st, sp, per, clr;
    logic [7:0] sd;
    logic [7:0] e_cnt;
    logic       e_busy, e_pulse, e_done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ld, st, sp, per, clr, input logic [7:0] sd,
                     input logic [7:0] ec, input logic eb, ep, ed);
    vec_t v;
    v.ld = ld; v.st = st; v.sp = sp; v.per = per; v.clr = clr; v.sd = sd;
    v.e_cnt = ec; v.e_busy = eb; v.e_pulse = ep; v.e_done = ed;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int ex_c [6];
    int ex_p [6];
    int ticks;
    bit found;
    int e;
    int hit;

    //  ld st sp per clr seed   count busy pulse done   (channel 0, PRESCALE 1)
    add(1, 0, 0, 0, 0, 8'd3,  8'd3, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'd0,  8'd3, 1, 0, 0);
    add(0, 0, 0, 0, 0, 8'd0,  8'd2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 8'd0,  8'd1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 8'd0,  8'd0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 8'd0,  8'd0, 0, 1, 1);  // 4th tick: one-shot expiry
    add(0, 0, 0, 0, 0, 8'd0,  8'd0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 8'd0,  8'd0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 8'd1,  8'd1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'd0,  8'd1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 8'd0,  8'd0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 8'd5,  8'd5, 0, 0, 0);  // load suppresses expiry
    add(1, 0, 0, 0, 0, 8'd0,  8'd0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'd0,  8'd0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 8'd0,  8'd0, 1, 1, 1);  // expiry beats clear_done
    add(0, 0, 0, 1, 1, 8'd0,  8'd0, 1, 1, 1);  // seed 0 periodic: every tick
    add(0, 0, 0, 0, 1, 8'd0,  8'd0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 8'd0,  8'd0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 8'd0,  8'd0, 1, 0, 0);  // restart from expired
    add(0, 0, 0, 0, 0, 8'd0,  8'd0, 0, 1, 1);
    add(1, 1, 1, 0, 0, 8'd7,  8'd7, 0, 0, 0);  // load wins over stop/start
    add(0, 1, 0, 0, 0, 8'd0,  8'd7, 1, 0, 0);
    add(0, 0, 1, 0, 0, 8'd0,  8'd7, 0, 0, 0);  // stop drops coincident tick
    add(0, 0, 0, 0, 0, 8'd0,  8'd7, 0, 0, 0);
    add(0, 1, 1, 0, 0, 8'd0,  8'd7, 0, 0, 0);  // stop wins over start

    Reset = 1'b1;
    idle_inputs();
    do_reset();

    // Directed vectors on channel 0.
    foreach (tbl[k]) begin
      idle_inputs();
      load[0] = tbl[k].ld; start[0] = tbl[k].st; stop[0] = tbl[k].sp;
      periodic[0] = tbl[k].per; clear_done[0] = tbl[k].clr; seed[7:0] = tbl[k].sd;
      cycle();
      check($sformatf("vec%0d_count", k), 32'(count1[7:0]), 32'(tbl[k].e_cnt));
      check($sformatf("vec%0d_busy",  k), 32'(busy1[0]),    32'(tbl[k].e_busy));
      check($sformatf("vec%0d_pulse", k), 32'(pulse1[0]),   32'(tbl[k].e_pulse));
      check($sformatf("vec%0d_done",  k), 32'(done1[0]),    32'(tbl[k].e_done));
    end
    idle_inputs();

    // Periodic channel 1, seed 2: period of three ticks.
    ex_c = '{1, 0, 2, 1, 0, 2};
    ex_p = '{0, 0, 1, 0, 0, 1};
    load[1] = 1'b1; seed[15:8] = 8'd2;
    cycle();
    idle_inputs(); start[1] = 1'b1; periodic[1] = 1'b1;
    cycle();
    check("per_start_count", 32'(count1[15:8]), 32'd2);
    start[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check($sformatf("per_count%0d", k), 32'(count1[15:8]), 32'(ex_c[k]));
      check($sformatf("per_pulse%0d", k), 32'(pulse1[1]), 32'(ex_p[k]));
      check($sformatf("per_busy%0d", k), 32'(busy1[1]), 32'd1);
    end
    idle_inputs(); stop[1] = 1'b1;
    cycle();
    idle_inputs();

    // Pause and resume, channel 2, seed 10: 11 ticks of running to expiry.
    load[2] = 1'b1; seed[23:16] = 8'd10;
    cycle();
    idle_inputs(); start[2] = 1'b1;
    cycle();
    idle_inputs();
    repeat (4) cycle();
    check("pause_pre_count", 32'(count1[23:16]), 32'd6);
    stop[2] = 1'b1;
    cycle();
    idle_inputs();
    for (int k = 0; k < 20; k++) begin
      cycle();
      check("pause_hold", 32'(count1[23:16]), 32'd6);
    end
    start[2] = 1'b1;
    cycle();
    idle_inputs();
    ticks = 4;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      cycle();
      ticks++;
      if (pulse1[2]) found = 1'b1;
      else if (k == 0) check("resume_count", 32'(count1[23:16]), 32'd5);
    end
    check("pause_expiry_found", 32'(found), 32'd1);
    check("pause_total_ticks", 32'(ticks), 32'd11);

    // PRESCALE 4: four channels with different seeds.
    do_reset();
    load = 4'hF; seed = {8'd2, 8'd0, 8'd3, 8'd1};
    cycle();                     // edge 0
    idle_inputs(); start = 4'hF;
    cycle();                     // edge 1
    idle_inputs();
    hit = -1;
    for (e = 2; e <= 20; e++) begin
      cycle();
      if (pulse4[0] && hit < 0) hit = e;
      if (e == 4) check("p4_ch0_count_after_first_tick", 32'(count4[7:0]), 32'd0);
    end
    check("p4_ch0_expiry_edge", 32'(hit), 32'd7);
    check("p4_all_done", 32'(done4), 32'hF);
    check("p4_any_done", 32'(any4), 32'd1);

    // Asynchronous reset between edges.
    do_reset();
    load[0] = 1'b1; load[1] = 1'b1; seed = {16'd0, 8'd0, 8'd200};
    cycle();
    idle_inputs(); start[0] = 1'b1; start[1] = 1'b1; periodic[1] = 1'b1;
    cycle();
    start = '0;
    repeat (3) cycle();
    check("pre_reset_pulse", 32'(pulse1[1]), 32'd1);
    #2;
    idle_inputs();
    Reset = 1'b1;
    #1;
    check("areset_count1", count1, 32'd0);
    check("areset_busy1",  32'(busy1),  32'd0);
    check("areset_pulse1", 32'(pulse1), 32'd0);
    check("areset_done1",  32'(done1),  32'd0);
    check("areset_count4", count4, 32'd0);
    check("areset_any4",   32'(any4),   32'd0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    repeat (5) cycle();
    check("post_reset_busy",  32'(busy1),  32'd0);
    check("post_reset_count", count1, 32'd0);

    // Randomised traffic against the model on both instances.
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        load[c]       = ($urandom_range(0, 15) == 0);
        start[c]      = ($urandom_range(0, 3) == 0);
        stop[c]       = ($urandom_range(0, 15) == 0);
        clear_done[c] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 7) == 0) periodic[c] = ~periodic[c];
        seed[c*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
